pkt_capture: RTL and testbench
==============================

// Module: pkt_capture
// PURPOSE
//  Ingress stage of the capture path, directly upstream of wr_ctrl. Accepts captured frames on an
//  Avalon-ST sink, stores each admitted frame whole (store-and-forward) in the shared data FIFO, and
//  on EOP issues one write descriptor (control, pkt_begin, pkt_end, write_address) to wr_ctrl.
//  Manages the DDR ring-buffer write pointer; drops whole frames when FIFO space is short.
// PARAMETERS
//  MAX_PKT_BYTES  1536  largest stored frame; longer frames are truncated; multiple of 4
//  FIFO_AW        9     data FIFO address width; depth = 2**FIFO_AW words
// PORTS
//  clk            in   1         single clock domain
//  reset          in   1         asynchronous, active-high
//  enable         in   1         0: every new frame is dropped; a frame in progress completes
//  buf_base       in   32        DDR ring base byte address, 4-byte aligned
//  buf_size       in   32        ring size in bytes, multiple of 4, >= MAX_PKT_BYTES
//  in_data        in   32        Avalon-ST data, first byte in [31:24]
//  in_valid       in   1         beat valid
//  in_sop/in_eop  in   1 each    start / end of frame
//  in_empty       in   2         unused bytes in EOP beat (0..3)
//  in_ready       out  1         sink ready
//  fifo_wrdata    out  32        data to FIFO
//  fifo_wr        out  1         FIFO write strobe
//  fifo_full      in   1         FIFO full
//  fifo_usedw     in   FIFO_AW+1 FIFO fill level in words
//  wr_ctrl        out  1         descriptor valid
//  wr_ctrl_rdy    in   1         wr_ctrl can accept a descriptor
//  control        out  32        [31:16] seq no, [1] ring wrapped, [0] truncated, others 0
//  pkt_begin      out  32        byte offset of first valid byte; always 0
//  pkt_end        out  32        stored frame length in bytes
//  write_address  out  32        DDR byte address of frame = buf_base + wr_ptr
//  pkt_count      out  32        descriptors accepted by wr_ctrl
//  drop_count     out  32        frames dropped
// BEHAVIOUR
//  Reset: in_ready=0, fifo_wr=0, fifo_wrdata=0, wr_ctrl=0, control/pkt_end/write_address=0,
//   counters=0, wr_ptr=0, seq=0, state=IDLE. in_ready rises the first cycle after reset deasserts.
//  Beat accepted = in_valid & in_ready. MAX_WORDS = MAX_PKT_BYTES/4.
//  FSM IDLE/CAPTURE/DROP/ISSUE. in_ready=1 in IDLE and DROP, ~fifo_full in CAPTURE, 0 in ISSUE.
//  IDLE: accepted beat without SOP is discarded silently. Accepted SOP beat:
//   - enable & (2**FIFO_AW - fifo_usedw >= MAX_WORDS) -> CAPTURE; word_cnt=1; beat written.
//   - otherwise -> DROP; nothing written.
//   - Single beat with both SOP and EOP follows the same rule, then goes to ISSUE or IDLE.
//  CAPTURE: each accepted beat is written while word_cnt < MAX_WORDS; later beats are discarded
//   and the truncated flag is set. SOP mid-frame is treated as data. EOP -> ISSUE.
//   byte_len = 4*written_words - (truncated ? 0 : in_empty).
//  DROP: discard beats until accepted EOP, then drop_count++ and -> IDLE (wraps at 2**32).
//  FIFO write: fifo_wr/fifo_wrdata registered; write appears 1 cycle after beat acceptance.
//  Ring: when the frame is admitted, if buf_size - wr_ptr < MAX_PKT_BYTES then wr_ptr=0 and the
//   wrapped flag is set. A frame therefore never straddles the ring end.
//  ISSUE: the cycle after the EOP beat, wr_ctrl=1 (coincident with the last fifo_wr).
//   Outputs: pkt_end=byte_len; write_address=buf_base+wr_ptr; control={seq,14'b0,wrapped,trunc}.
//   All descriptor outputs are held stable while wr_ctrl=1.
//   On wr_ctrl & wr_ctrl_rdy: wr_ctrl=0 next cycle; wr_ptr += roundup4(byte_len);
//   seq++ (16-bit wrap); pkt_count++; flags cleared; -> IDLE.
//  Descriptor outputs keep their last values until the next issue.
//  Reset mid-frame: state is lost; FIFO flush is the system's responsibility on the same reset.
// TESTING
//  T1 normal: base=0x8000, 8-beat frame, empty=0, wr_ctrl_rdy=1 -> 8 fifo_wr (values in order);
//     pkt_end=32, write_address=0x8000, control=0x0; next frame at 0x8020, seq=1.
//  T2 odd length: 3 beats, in_empty=3 -> pkt_end=9; next write_address advances by 12.
//  T3 backpressure: wr_ctrl_rdy=0 for 5 cycles -> wr_ctrl and descriptor held; in_ready=0;
//     no new beats are accepted until the handshake completes.
//  T4 drop: fifo_usedw=200 (depth 512, MAX_WORDS 384) at SOP -> no fifo_wr; drop_count=1;
//     next frame with usedw=0 is captured normally.
//  T5 truncate: 400-beat frame -> 384 fifo_wr; pkt_end=1536; control[0]=1.
//  T6 wrap: buf_size=4096, wr_ptr=3072 at SOP -> write_address=buf_base; control[1]=1.
//     Reset asserted mid-frame clears all outputs and counters asynchronously.

Source files
------------

// File: rtl/pkt_capture.sv
// Ingress capture stage: admits whole Avalon-ST frames into the data FIFO and issues one write
// descriptor per stored frame to wr_ctrl, advancing the DDR ring-buffer write pointer.
module pkt_capture #(
    parameter int unsigned MAX_PKT_BYTES = 1536,
    parameter int unsigned FIFO_AW       = 9
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [31:0]        buf_base_i,
    input  logic [31:0]        buf_size_i,
    input  logic [31:0]        in_data_i,
    input  logic               in_valid_i,
    input  logic               in_sop_i,
    input  logic               in_eop_i,
    input  logic [1:0]         in_empty_i,
    output logic               in_ready_o,
    output logic [31:0]        fifo_wrdata_o,
    output logic               fifo_wr_o,
    input  logic               fifo_full_i,
    input  logic [FIFO_AW:0]   fifo_usedw_i,
    output logic               wr_ctrl_o,
    input  logic               wr_ctrl_rdy_i,
    output logic [31:0]        control_o,
    output logic [31:0]        pkt_begin_o,
    output logic [31:0]        pkt_end_o,
    output logic [31:0]        write_address_o,
    output logic [31:0]        pkt_count_o,
    output logic [31:0]        drop_count_o
);
    localparam int unsigned MaxWords = MAX_PKT_BYTES / 4;
    localparam int unsigned CntW     = $clog2(MaxWords + 1);
    localparam int unsigned Depth    = 1 << FIFO_AW;

    typedef enum logic [1:0] {StIdle, StCapture, StDrop, StIssue} state_e;

    state_e          state_q, state_d;
    logic            run_q;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;
    logic            trunc_q, trunc_d;
    logic            wrap_q, wrap_d;
    logic [31:0]     wr_ptr_q, wr_ptr_d;
    logic [15:0]     seq_q, seq_d;
    logic [31:0]     pkt_count_q, pkt_count_d;
    logic [31:0]     drop_count_q, drop_count_d;
    logic            fifo_wr_q, fifo_wr_d;
    logic [31:0]     fifo_wrdata_q, fifo_wrdata_d;
    logic [31:0]     control_q, control_d;
    logic [31:0]     pkt_end_q, pkt_end_d;
    logic [31:0]     write_address_q, write_address_d;
    logic            accept, fits, need_wrap, load_desc;

    assign accept    = in_valid_i & in_ready_o;
    // Admit only when a maximum-size frame is guaranteed to fit in the FIFO.
    assign fits      = (32'(fifo_usedw_i) + MaxWords) <= Depth;
    // 33-bit compare so a frame never straddles the ring end, even near 2**32.
    assign need_wrap = ({1'b0, wr_ptr_q} + 33'(MAX_PKT_BYTES)) > {1'b0, buf_size_i};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        trunc_d         = trunc_q;
        wrap_d          = wrap_q;
        wr_ptr_d        = wr_ptr_q;
        seq_d           = seq_q;
        pkt_count_d     = pkt_count_q;
        drop_count_d    = drop_count_q;
        fifo_wr_d       = 1'b0;
        fifo_wrdata_d   = fifo_wrdata_q;
        control_d       = control_q;
        pkt_end_d       = pkt_end_q;
        write_address_d = write_address_q;
        load_desc       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept && in_sop_i) begin
                    if (enable_i && fits) begin
                        fifo_wr_d     = 1'b1;
                        fifo_wrdata_d = in_data_i;
                        word_cnt_d    = CntW'(1);
                        trunc_d       = 1'b0;
                        wrap_d        = need_wrap;
                        if (need_wrap) begin
                            wr_ptr_d = 32'd0;
                        end
                        if (in_eop_i) begin
                            load_desc = 1'b1;
                            state_d   = StIssue;
                        end else begin
                            state_d = StCapture;
                        end
                    end else if (in_eop_i) begin
                        drop_count_d = drop_count_q + 32'd1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StCapture: begin
                if (accept) begin
                    if (32'(word_cnt_q) < MaxWords) begin
                        fifo_wr_d     = 1'b1;
                        fifo_wrdata_d = in_data_i;
                        word_cnt_d    = word_cnt_q + CntW'(1);
                    end else begin
                        trunc_d = 1'b1;
                    end
                    if (in_eop_i) begin
                        load_desc = 1'b1;
                        state_d   = StIssue;
                    end
                end
            end
            StDrop: begin
                if (accept && in_eop_i) begin
                    drop_count_d = drop_count_q + 32'd1;
                    state_d      = StIdle;
                end
            end
            StIssue: begin
                if (wr_ctrl_rdy_i) begin
                    wr_ptr_d    = wr_ptr_q + (32'(word_cnt_q) << 2);
                    seq_d       = seq_q + 16'd1;
                    pkt_count_d = pkt_count_q + 32'd1;
                    trunc_d     = 1'b0;
                    wrap_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_desc) begin
            pkt_end_d       = (32'(word_cnt_d) << 2) - (trunc_d ? 32'd0 : 32'(in_empty_i));
            write_address_d = buf_base_i + wr_ptr_d;
            control_d       = {seq_q, 14'd0, wrap_d, trunc_d};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            run_q           <= 1'b0;
            word_cnt_q      <= '0;
            trunc_q         <= 1'b0;
            wrap_q          <= 1'b0;
            wr_ptr_q        <= 32'd0;
            seq_q           <= 16'd0;
            pkt_count_q     <= 32'd0;
            drop_count_q    <= 32'd0;
            fifo_wr_q       <= 1'b0;
            fifo_wrdata_q   <= 32'd0;
            control_q       <= 32'd0;
            pkt_end_q       <= 32'd0;
            write_address_q <= 32'd0;
        end else begin
            run_q           <= 1'b1;
            word_cnt_q      <= word_cnt_d;
            trunc_q         <= trunc_d;
            wrap_q          <= wrap_d;
            wr_ptr_q        <= wr_ptr_d;
            seq_q           <= seq_d;
            pkt_count_q     <= pkt_count_d;
            drop_count_q    <= drop_count_d;
            fifo_wr_q       <= fifo_wr_d;
            fifo_wrdata_q   <= fifo_wrdata_d;
            control_q       <= control_d;
            pkt_end_q       <= pkt_end_d;
            write_address_q <= write_address_d;
        end
    end

    // run_q keeps the sink closed until the first clock after reset release.
    always_comb begin
        in_ready_o = 1'b0;
        wr_ctrl_o  = 1'b0;
        unique case (state_q)
            StIdle, StDrop: in_ready_o = run_q;
            StCapture:      in_ready_o = run_q & ~fifo_full_i;
            StIssue:        wr_ctrl_o  = 1'b1;
            default:        ;
        endcase
    end

    assign fifo_wr_o       = fifo_wr_q;
    assign fifo_wrdata_o   = fifo_wrdata_q;
    assign control_o       = control_q;
    assign pkt_begin_o     = 32'd0;
    assign pkt_end_o       = pkt_end_q;
    assign write_address_o = write_address_q;
    assign pkt_count_o     = pkt_count_q;
    assign drop_count_o    = drop_count_q;
endmodule

// File: tb/tb_pkt_capture.sv
// Scoreboard bench for pkt_capture: a frame-level model queues expected FIFO words and
// descriptors; a monitor pops and compares whenever the DUT writes or hands off a descriptor.
module tb_pkt_capture;
    localparam int unsigned MaxBytes = 1536;
    localparam int unsigned Aw       = 9;
    localparam int unsigned MaxWords = MaxBytes / 4;
    localparam int unsigned Depth    = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [31:0]   buf_base = 32'h0000_8000;
    logic [31:0]   buf_size = 32'd4096;
    logic [31:0]   in_data = 32'd0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [1:0]    in_empty = 2'd0;
    logic          in_ready;
    logic [31:0]   fifo_wrdata;
    logic          fifo_wr;
    logic          fifo_full = 1'b0;
    logic [Aw:0]   fifo_usedw = '0;
    logic          wr_ctrl;
    logic          wr_ctrl_rdy = 1'b1;
    logic [31:0]   control, pkt_begin, pkt_end, write_address, pkt_count, drop_count;

    pkt_capture #(.MAX_PKT_BYTES(MaxBytes), .FIFO_AW(Aw)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .buf_base_i(buf_base),
        .buf_size_i(buf_size), .in_data_i(in_data), .in_valid_i(in_valid), .in_sop_i(in_sop),
        .in_eop_i(in_eop), .in_empty_i(in_empty), .in_ready_o(in_ready),
        .fifo_wrdata_o(fifo_wrdata), .fifo_wr_o(fifo_wr), .fifo_full_i(fifo_full),
        .fifo_usedw_i(fifo_usedw), .wr_ctrl_o(wr_ctrl), .wr_ctrl_rdy_i(wr_ctrl_rdy),
        .control_o(control), .pkt_begin_o(pkt_begin), .pkt_end_o(pkt_end),
        .write_address_o(write_address), .pkt_count_o(pkt_count), .drop_count_o(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pend;
        logic [31:0] addr;
        logic [31:0] ctrl;
    } desc_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] data_q[$];
    desc_t       desc_q[$];
    desc_t       mon_d;
    desc_t       t3_exp;
    logic [31:0] m_ptr = 32'd0;
    logic [15:0] m_seq = 16'd0;
    int          m_pkts = 0;
    int          m_drops = 0;
    bit          mon_en = 1'b0;
    bit          gaps = 1'b0;
    int          rdy_mode = 0;   // 0: ready, 1: not ready, 2: random
    bit          full_rnd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Handshake inputs change just after the rising edge so they are stable at sampling.
    always @(posedge clk) begin
        #1;
        wr_ctrl_rdy = (rdy_mode == 0) ? 1'b1 :
                      (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        fifo_full   = full_rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (fifo_wr) begin
                if (data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fifo_wr_unexpected: got 0x%08h expected no write", fifo_wrdata);
                end else begin
                    chk("fifo_data", fifo_wrdata, data_q.pop_front());
                end
            end
            if (wr_ctrl && wr_ctrl_rdy) begin
                if (desc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL desc_unexpected: got pkt_end 0x%08h expected none", pkt_end);
                end else begin
                    mon_d = desc_q.pop_front();
                    chk("desc_pkt_end", pkt_end, mon_d.pend);
                    chk("desc_address", write_address, mon_d.addr);
                    chk("desc_control", control, mon_d.ctrl);
                    chk("desc_pkt_begin", pkt_begin, 32'd0);
                end
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the beat is taken.
    task automatic drive_beat(input logic [31:0] d, input bit sop, input bit eop,
                              input logic [1:0] emp);
        int guard = 0;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = emp;
        in_valid = 1'b1;
        while (!in_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout: got in_ready=0 expected 1 within 3000 cycles");
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int nbeats, input int emp, input int usedw, input bit en);
        bit          admit, wrap, trunc;
        int          words;
        desc_t       d;
        logic [31:0] w;
        fifo_usedw = usedw[Aw:0];
        enable     = en;
        admit      = en && (Depth - usedw >= MaxWords);
        if (admit) begin
            wrap  = (longint'(buf_size) - longint'(m_ptr)) < longint'(MaxBytes);
            if (wrap) m_ptr = 32'd0;
            trunc = nbeats > MaxWords;
            words = trunc ? MaxWords : nbeats;
            d.pend = 32'(words * 4 - (trunc ? 0 : emp));
            d.addr = buf_base + m_ptr;
            d.ctrl = {m_seq, 14'd0, wrap, trunc};
            desc_q.push_back(d);
            m_ptr  = m_ptr + ((d.pend + 32'd3) / 32'd4) * 32'd4;
            m_seq++;
            m_pkts++;
        end else begin
            m_drops++;
        end
        for (int i = 0; i < nbeats; i++) begin
            w = $urandom;
            if (admit && i < MaxWords) data_q.push_back(w);
            drive_beat(w, i == 0, i == nbeats - 1, 2'(emp));
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((data_q.size() != 0 || desc_q.size() != 0 || wr_ctrl) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d words %0d descs pending expected 0",
                     data_q.size(), desc_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
        chk("rst_control", control, 32'd0);
        chk("rst_pkt_end", pkt_end, 32'd0);
        chk("rst_address", write_address, 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_drop_count", drop_count, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 32'(in_ready), 32'd1);
        @(negedge clk);
        mon_en = 1'b1;

        // Normal frames and odd length
        send_frame(8, 0, 0, 1'b1);
        send_frame(8, 0, 0, 1'b1);
        wait_drain();
        chk("t1_addr2", write_address, 32'h0000_8020);
        chk("t1_ctrl2", control, 32'h0001_0000);
        send_frame(3, 3, 0, 1'b1);
        send_frame(2, 0, 0, 1'b1);
        wait_drain();
        chk("t2_addr", write_address, 32'h0000_804C);

        // Descriptor backpressure
        rdy_mode = 1;
        send_frame(2, 1, 0, 1'b1);
        t3_exp = desc_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_wr_ctrl_held", 32'(wr_ctrl), 32'd1);
            chk("t3_in_ready_low", 32'(in_ready), 32'd0);
            chk("t3_pkt_end_held", pkt_end, t3_exp.pend);
            chk("t3_address_held", write_address, t3_exp.addr);
        end
        rdy_mode = 0;
        wait_drain();

        // Drops: FIFO space boundary, disabled, single-beat
        send_frame(5, 0, 200, 1'b1);
        chk("t4_drop1", drop_count, 32'(m_drops));
        send_frame(4, 0, 0, 1'b1);
        send_frame(3, 0, 129, 1'b1);
        send_frame(3, 2, 128, 1'b1);
        send_frame(3, 0, 0, 1'b0);
        send_frame(1, 2, 300, 1'b1);
        send_frame(1, 2, 0, 1'b1);
        wait_drain();
        chk("t4_drops", drop_count, 32'(m_drops));

        // Truncation
        send_frame(400, 0, 0, 1'b1);
        wait_drain();
        chk("t5_pkt_end", pkt_end, 32'd1536);
        chk("t5_trunc", 32'(control[0]), 32'd1);

        // Randomized traffic
        gaps     = 1'b1;
        rdy_mode = 2;
        full_rnd = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) drive_beat($urandom, 1'b0, 1'($urandom), 2'd0);
            send_frame(($urandom_range(0, 9) == 0) ? int'($urandom_range(380, 390))
                                                   : int'($urandom_range(1, 24)),
                       int'($urandom_range(0, 3)),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 512))
                                                   : int'($urandom_range(0, 128)),
                       $urandom_range(0, 7) != 0);
        end
        wait_drain();
        rdy_mode = 0;
        full_rnd = 1'b0;
        gaps     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rnd_pkt_count", pkt_count, 32'(m_pkts));
        chk("rnd_drop_count", drop_count, 32'(m_drops));

        // Reset mid-frame, no expectations queued for the aborted frame
        mon_en = 1'b0;
        enable = 1'b1;
        fifo_usedw = '0;
        drive_beat(32'hA5A5_0001, 1'b1, 1'b0, 2'd0);
        drive_beat(32'hA5A5_0002, 1'b0, 1'b0, 2'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("mid_rst_wrdata", fifo_wrdata, 32'd0);
        chk("mid_rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
        chk("mid_rst_control", control, 32'd0);
        chk("mid_rst_pkt_end", pkt_end, 32'd0);
        chk("mid_rst_address", write_address, 32'd0);
        chk("mid_rst_pkt_count", pkt_count, 32'd0);
        chk("mid_rst_drop_count", drop_count, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        m_ptr   = 32'd0;
        m_seq   = 16'd0;
        m_pkts  = 0;
        m_drops = 0;
        @(negedge clk);
        mon_en = 1'b1;

        // Ring wrap: three 1 KiB frames bring wr_ptr to 3072
        for (int i = 0; i < 3; i++) send_frame(256, 0, 0, 1'b1);
        send_frame(4, 0, 0, 1'b1);
        wait_drain();
        chk("t6_address", write_address, 32'h0000_8000);
        chk("t6_control", control, 32'h0003_0002);
        chk("t6_pkt_count", pkt_count, 32'd4);
        chk("end_data_q_empty", 32'(data_q.size()), 32'd0);
        chk("end_desc_q_empty", 32'(desc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
